// File: rtl/vector_reduce_pkg.sv
// Shared opcode constants, the decoded operation kind and the sideband bundle
// that travels alongside each beat through the reduction pipeline.
package vector_reduce_pkg;

    localparam logic [7:0] OP_PASS = 8'd0;
    localparam logic [7:0] OP_SUM  = 8'd1;
    localparam logic [7:0] OP_MAX  = 8'd2;

    // Widest chain id the bundle can carry; narrower ids are zero-extended.
    localparam int SB_CHAIN_W = 8;

    typedef enum logic [1:0] {
        KIND_PASS = 2'd0,
        KIND_SUM  = 2'd1,
        KIND_MAX  = 2'd2
    } op_kind_e;

    typedef struct packed {
        logic                  valid;
        logic [1:0]            eof;
        logic [1:0]            bof;
        logic [SB_CHAIN_W-1:0] chain_id;
        op_kind_e              op;
    } sideband_t;

    localparam int SB_WIDTH = $bits(sideband_t);

    // Unknown firmware opcodes fall back to pass-through.
    function automatic op_kind_e decode_op(input logic [7:0] op);
        case (op)
            OP_SUM:  return KIND_SUM;
            OP_MAX:  return KIND_MAX;
            default: return KIND_PASS;
        endcase
    endfunction

endpackage

// File: rtl/reduce_tree_level.sv
// One registered pairwise level of the reduction tree: halves the lane count
// with either an add or an unsigned compare-select, carrying sideband along.
module reduce_tree_level #(
    parameter int IN_LANES   = 8,
    parameter int DATA_WIDTH = 32,
    parameter int SB_WIDTH   = 15
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  i_is_max,
    input  logic [IN_LANES*DATA_WIDTH-1:0]        i_lanes,
    input  logic [SB_WIDTH-1:0]                   i_sb,
    output logic [(IN_LANES/2)*DATA_WIDTH-1:0]    o_lanes,
    output logic [SB_WIDTH-1:0]                   o_sb
);

    localparam int OUT_LANES = IN_LANES / 2;
    localparam int DW        = DATA_WIDTH;

    logic [OUT_LANES*DW-1:0] w_next;
    logic [OUT_LANES*DW-1:0] r_lanes;
    logic [SB_WIDTH-1:0]     r_sb;

    genvar gi;
    generate
        for (gi = 0; gi < OUT_LANES; gi++) begin : g_pair
            logic [DW-1:0] w_a;
            logic [DW-1:0] w_b;
            assign w_a = i_lanes[(2*gi)*DW +: DW];
            assign w_b = i_lanes[(2*gi+1)*DW +: DW];
            // Strict compare keeps the lower-index lane on ties.
            assign w_next[gi*DW +: DW] = i_is_max ? ((w_b > w_a) ? w_b : w_a)
                                                  : (w_a + w_b);
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lanes <= '0;
            r_sb    <= '0;
        end else begin
            r_lanes <= w_next;
            r_sb    <= i_sb;
        end
    end

    assign o_lanes = r_lanes;
    assign o_sb    = r_sb;

endmodule

// File: rtl/vector_scalar_reduce.sv
// Per-chain reduction stage: passes a vector through or reduces it to a SUM/MAX
// scalar in lane 0, with the opcode chosen per beat from a firmware table.
module vector_scalar_reduce
    import vector_reduce_pkg::*;
#(
    parameter int                      N                   = 8,
    parameter int                      DATA_WIDTH          = 32,
    parameter int                      MAX_CHAINS          = 4,
    parameter logic [7:0]              PERSONAL_CONFIG_ID  = 8'd0,
    parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE_OP = '0,
    parameter int                      CHAIN_W             = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tracing,
    input  logic                       valid_in,
    input  logic [1:0]                 eof_in,
    input  logic [1:0]                 bof_in,
    input  logic [CHAIN_W-1:0]         chainId_in,
    input  logic [7:0]                 configId,
    input  logic [7:0]                 configData,
    input  logic [N*DATA_WIDTH-1:0]    vector_in,
    output logic [N*DATA_WIDTH-1:0]    vector_out,
    output logic                       valid_out,
    output logic [1:0]                 eof_out,
    output logic [1:0]                 bof_out,
    output logic [CHAIN_W-1:0]         chainId_out
);

    localparam int         LEVELS      = $clog2(N);
    localparam int         DW          = DATA_WIDTH;
    localparam int         TREE_W      = (2*N - 1) * DW;
    localparam logic [8:0] CHAIN_LIMIT = 9'(MAX_CHAINS);

    logic [7:0]        r_fw_op [MAX_CHAINS];
    logic [7:0]        r_cfg_cnt;

    sideband_t         w_in_sb;
    sideband_t         r_in_sb;
    logic [N*DW-1:0]   r_in_vec;
    logic [7:0]        w_in_op;

    // Lane triangle: level l occupies N>>l lanes starting at lane 2N - 2*(N>>l).
    logic [TREE_W-1:0] w_tree;
    sideband_t         w_sb [LEVELS+1];
    logic [N*DW-1:0]   r_pass [LEVELS];
    logic              r_tracing_out;
    logic [DW-1:0]     w_out_lane;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MAX_CHAINS; k++) begin
                r_fw_op[k] <= INITIAL_FIRMWARE_OP[k*8 +: 8];
            end
            r_cfg_cnt <= '0;
        end else if (!tracing) begin
            if (configId == PERSONAL_CONFIG_ID) begin
                if ({1'b0, r_cfg_cnt} < CHAIN_LIMIT) begin
                    r_fw_op[r_cfg_cnt[CHAIN_W-1:0]] <= configData;
                end
                r_cfg_cnt <= r_cfg_cnt + 8'd1;
            end else begin
                r_cfg_cnt <= '0;
            end
        end
    end

    // The opcode is resolved here and rides with the beat, so later firmware
    // writes never reach beats already inside the tree.
    always_comb begin
        w_in_op = OP_PASS;
        if (9'(chainId_in) < CHAIN_LIMIT) begin
            w_in_op = r_fw_op[chainId_in];
        end
        w_in_sb          = '0;
        w_in_sb.valid    = valid_in;
        w_in_sb.eof      = eof_in;
        w_in_sb.bof      = bof_in;
        w_in_sb.chain_id = SB_CHAIN_W'(chainId_in);
        w_in_sb.op       = decode_op(w_in_op);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_vec <= '0;
            r_in_sb  <= '0;
        end else begin
            r_in_vec <= vector_in;
            r_in_sb  <= w_in_sb;
        end
    end

    assign w_tree[0 +: N*DW] = r_in_vec;
    assign w_sb[0]           = r_in_sb;

    genvar gi;
    generate
        for (gi = 0; gi < LEVELS; gi++) begin : g_level
            localparam int IN_LANES = N >> gi;
            localparam int IN_OFF   = (2*N - 2*IN_LANES) * DW;
            localparam int OUT_OFF  = (2*N - IN_LANES) * DW;

            reduce_tree_level #(
                .IN_LANES   (IN_LANES),
                .DATA_WIDTH (DW),
                .SB_WIDTH   (SB_WIDTH)
            ) u_level (
                .clk      (clk),
                .reset    (reset),
                .i_is_max (w_sb[gi].op == KIND_MAX),
                .i_lanes  (w_tree[IN_OFF +: IN_LANES*DW]),
                .i_sb     (w_sb[gi]),
                .o_lanes  (w_tree[OUT_OFF +: (IN_LANES/2)*DW]),
                .o_sb     (w_sb[gi+1])
            );
        end
    endgenerate

    // Full vector delay line matching the tree depth, used for PASS beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < LEVELS; k++) begin
                r_pass[k] <= '0;
            end
            r_tracing_out <= 1'b0;
        end else begin
            r_pass[0] <= r_in_vec;
            for (int k = 1; k < LEVELS; k++) begin
                r_pass[k] <= r_pass[k-1];
            end
            r_tracing_out <= tracing;
        end
    end

    assign w_out_lane = w_tree[(2*N - 2)*DW +: DW];

    always_comb begin
        vector_out = r_pass[LEVELS-1];
        if (w_sb[LEVELS].op != KIND_PASS) begin
            vector_out          = '0;
            vector_out[DW-1:0]  = w_out_lane;
        end
    end

    // Tracing is captured on the same edge as the final tree level, so beats
    // that emerge during config mode are dropped.
    assign valid_out   = w_sb[LEVELS].valid & r_tracing_out;
    assign eof_out     = w_sb[LEVELS].eof;
    assign bof_out     = w_sb[LEVELS].bof;
    assign chainId_out = w_sb[LEVELS].chain_id[CHAIN_W-1:0];

endmodule

// File: tb/tb_vector_scalar_reduce.sv
// Scoreboard bench for vector_scalar_reduce: stimulus pushes reference results,
// a negedge monitor pops and compares whenever an output is due.
module tb_vector_scalar_reduce;

    localparam int N   = 8;
    localparam int DW  = 32;
    localparam int MC  = 4;
    localparam int LAT = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            tracing;
    logic            valid_in;
    logic [1:0]      eof_in;
    logic [1:0]      bof_in;
    logic [1:0]      chainId_in;
    logic [7:0]      configId;
    logic [7:0]      configData;
    logic [N*DW-1:0] vector_in;
    logic [N*DW-1:0] vector_out;
    logic            valid_out;
    logic [1:0]      eof_out;
    logic [1:0]      bof_out;
    logic [1:0]      chainId_out;

    vector_scalar_reduce dut (
        .clk         (clk),
        .reset       (reset),
        .tracing     (tracing),
        .valid_in    (valid_in),
        .eof_in      (eof_in),
        .bof_in      (bof_in),
        .chainId_in  (chainId_in),
        .configId    (configId),
        .configData  (configData),
        .vector_in   (vector_in),
        .vector_out  (vector_out),
        .valid_out   (valid_out),
        .eof_out     (eof_out),
        .bof_out     (bof_out),
        .chainId_out (chainId_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*DW-1:0] vec;
        logic [1:0]      eof;
        logic [1:0]      bof;
        logic [1:0]      chain;
        int              due;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       last_tracing = 1'b0;
    logic       mon_en = 1'b0;
    logic [7:0] fw [MC];
    int         cfg_cnt = 0;

    always @(posedge clk) begin
        cyc++;
        last_tracing = tracing;
    end

    // Reference: plain arithmetic over the lanes, opcode semantics only.
    function automatic logic [N*DW-1:0] ref_result(input logic [7:0] op, input logic [N*DW-1:0] v);
        logic [N*DW-1:0] r;
        logic [DW-1:0]   acc;
        r   = '0;
        acc = '0;
        if (op == 8'd1) begin
            for (int i = 0; i < N; i++) acc = acc + v[i*DW +: DW];
            r[DW-1:0] = acc;
        end else if (op == 8'd2) begin
            for (int i = 0; i < N; i++) if (v[i*DW +: DW] > acc) acc = v[i*DW +: DW];
            r[DW-1:0] = acc;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [N*DW-1:0] seq_vec(input int base);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(base + i);
        return v;
    endfunction

    function automatic logic [N*DW-1:0] rand_vec();
        logic [N*DW-1:0] v;
        int mode;
        mode = int'($urandom_range(0, 3));
        for (int i = 0; i < N; i++) begin
            case (mode)
                1:       v[i*DW +: DW] = 32'hFFFF_FFFF;
                2:       v[i*DW +: DW] = DW'($urandom_range(0, 3));
                default: v[i*DW +: DW] = $urandom;
            endcase
        end
        return v;
    endfunction

    // One cycle of stimulus; updates the firmware model after the beat's lookup.
    task automatic step(input logic v, input logic tr, input logic [1:0] ch,
                        input logic [N*DW-1:0] vec, input logic [7:0] cid, input logic [7:0] cdata);
        exp_t e;
        logic [1:0] eo;
        logic [1:0] bo;
        @(negedge clk);
        eo = 2'($urandom);
        bo = 2'($urandom);
        valid_in   = v;
        tracing    = tr;
        chainId_in = ch;
        vector_in  = vec;
        eof_in     = eo;
        bof_in     = bo;
        configId   = cid;
        configData = cdata;
        if (v) begin
            e.vec   = ref_result(fw[ch], vec);
            e.eof   = eo;
            e.bof   = bo;
            e.chain = ch;
            e.due   = cyc + LAT;
            sb_q.push_back(e);
        end
        if (!tr) begin
            if (cid == 8'd0) begin
                if (cfg_cnt < MC) fw[cfg_cnt] = cdata;
                cfg_cnt = (cfg_cnt + 1) % 256;
            end else begin
                cfg_cnt = 0;
            end
        end
    endtask

    task automatic idle(input int n, input logic tr);
        for (int i = 0; i < n; i++) step(1'b0, tr, 2'd0, '0, 8'd9, 8'd0);
    endtask

    task automatic check_zero_outputs(input string tag);
        checks++;
        if (valid_out !== 1'b0 || vector_out !== '0 || eof_out !== 2'b0 ||
            bof_out !== 2'b0 || chainId_out !== 2'b0) begin
            errors++;
            $display("FAIL %s: valid=%b chain=%0d eof=%0d bof=%0d lane0=%h, required all zero",
                     tag, valid_out, chainId_out, eof_out, bof_out, vector_out[DW-1:0]);
        end else begin
            $display("%s: outputs zero", tag);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !reset) begin
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                e = sb_q.pop_front();
                checks++;
                if (last_tracing) begin
                    if (valid_out !== 1'b1 || vector_out !== e.vec || eof_out !== e.eof ||
                        bof_out !== e.bof || chainId_out !== e.chain) begin
                        errors++;
                        $display("FAIL beat@%0d: valid=%b chain=%0d eof=%0d bof=%0d lane0=%h lane1=%h, required valid=1 chain=%0d eof=%0d bof=%0d lane0=%h lane1=%h",
                                 cyc, valid_out, chainId_out, eof_out, bof_out, vector_out[DW-1:0], vector_out[DW +: DW],
                                 e.chain, e.eof, e.bof, e.vec[DW-1:0], e.vec[DW +: DW]);
                    end else begin
                        $display("beat@%0d chain=%0d lane0=%h ok", cyc, chainId_out, vector_out[DW-1:0]);
                    end
                end else begin
                    if (valid_out !== 1'b0) begin
                        errors++;
                        $display("FAIL dropped@%0d: valid=%b, required 0", cyc, valid_out);
                    end else begin
                        $display("beat@%0d dropped while tracing low", cyc);
                    end
                end
            end else begin
                checks++;
                if (valid_out !== 1'b0) begin
                    errors++;
                    $display("FAIL spurious@%0d: valid=%b, required 0", cyc, valid_out);
                end
            end
        end
    end

    initial begin
        logic [N*DW-1:0] v;
        reset = 1'b1; tracing = 1'b1; valid_in = 1'b0; eof_in = '0; bof_in = '0;
        chainId_in = '0; configId = 8'd9; configData = '0; vector_in = '0;
        for (int k = 0; k < MC; k++) fw[k] = 8'd0;
        #1;
        check_zero_outputs("reset_state");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;

        // Default firmware passes; config bus ignored while tracing.
        step(1'b1, 1'b1, 2'd2, seq_vec(1), 8'd0, 8'd1);
        idle(5, 1'b1);

        // Firmware load then SUM and MAX beats.
        step(1'b0, 1'b0, 2'd0, '0, 8'd0, 8'd1);
        step(1'b0, 1'b0, 2'd0, '0, 8'd0, 8'd2);
        step(1'b0, 1'b0, 2'd0, '0, 8'd0, 8'd0);
        step(1'b0, 1'b0, 2'd0, '0, 8'd0, 8'd1);
        step(1'b0, 1'b0, 2'd0, '0, 8'd0, 8'd2);
        step(1'b1, 1'b1, 2'd0, seq_vec(1), 8'd0, 8'd3);
        v = '0; v[0 +: DW] = 32'd5; v[DW +: DW] = 32'd9; v[2*DW +: DW] = 32'd3;
        step(1'b1, 1'b1, 2'd1, v, 8'd0, 8'd3);
        step(1'b1, 1'b1, 2'd0, {N{32'hFFFF_FFFF}}, 8'd0, 8'd0);
        idle(5, 1'b1);

        // Back-to-back beats across all chains.
        for (int c = 0; c < MC; c++) step(1'b1, 1'b1, 2'(c), seq_vec(10 * c + 3), 8'd0, 8'd0);
        idle(5, 1'b1);

        // Tracing drops two cycles after a beat enters; foreign id clears the counter.
        step(1'b1, 1'b1, 2'd0, seq_vec(100), 8'd0, 8'd0);
        step(1'b0, 1'b1, 2'd0, '0, 8'd0, 8'd0);
        step(1'b0, 1'b0, 2'd0, '0, 8'd5, 8'd0);
        step(1'b0, 1'b0, 2'd0, '0, 8'd5, 8'd0);
        step(1'b0, 1'b0, 2'd0, '0, 8'd0, 8'd2);
        idle(2, 1'b0);
        step(1'b1, 1'b1, 2'd0, seq_vec(7), 8'd0, 8'd0);
        idle(5, 1'b1);

        // Randomized traffic with interleaved config-mode windows.
        for (int i = 0; i < 300; i++) begin
            logic tr;
            logic [7:0] cd;
            tr = ($urandom_range(0, 99) < 85);
            cd = ($urandom_range(0, 4) == 4) ? 8'hC5 : 8'($urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), tr, 2'($urandom), rand_vec(),
                 ($urandom_range(0, 3) == 0) ? 8'd3 : 8'd0, cd);
        end
        idle(6, 1'b1);

        // Reset with three beats in flight.
        for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 2'(c), seq_vec(50 + c), 8'd0, 8'd0);
        #2;
        reset = 1'b1;
        valid_in = 1'b0;
        sb_q.delete();
        for (int k = 0; k < MC; k++) fw[k] = 8'd0;
        cfg_cnt = 0;
        #1;
        check_zero_outputs("async_reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b1, 2'd3, seq_vec(200), 8'd0, 8'd0);
        idle(8, 1'b1);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_scalar_reduce.md
# vector_scalar_reduce

Pipelined per-chain reduction stage directly downstream of the vector-vector ALU. Consumes the ALU's N-lane vector stream with its valid/eof/bof/chainId sideband. Depending on a per-chain firmware opcode, it either passes the vector through or reduces it to a scalar (sum or max) placed in lane 0. Firmware is loaded over the shared configId/configData byte bus while tracing is low.

## Interface
- N, 8, lanes per vector; power of two, ≥2
- DATA_WIDTH, 32, bits per lane
- MAX_CHAINS, 4, number of firmware chains
- PERSONAL_CONFIG_ID, 0, configId value that addresses this block
- INITIAL_FIRMWARE_OP, all 0, [7:0] opcode per chain loaded at reset
- clk  in  1  single clock
- reset  in  1  asynchronous, active-high
- tracing  in  1  1 = stream mode, 0 = config mode
- valid_in  in  1  input vector valid
- eof_in  in  2  end-of-frame flags, two levels
- bof_in  in  2  begin-of-frame flags, two levels
- chainId_in  in  $clog2(MAX_CHAINS)  chain selecting the firmware entry
- configId  in  8  config bus target
- configData  in  8  config bus byte
- vector_in  in  N×DATA_WIDTH  input lanes
- vector_out  out  N×DATA_WIDTH  result lanes
- valid_out  out  1  output valid
- eof_out  out  2  delayed eof_in
- bof_out  out  2  delayed bof_in
- chainId_out  out  $clog2(MAX_CHAINS)  delayed chainId_in

## Operation
- Opcodes:
  - 0 = PASS: vector_out = vector_in.
  - 1 = SUM: lane0 = Σ lanes mod 2^DATA_WIDTH; lanes 1..N-1 = 0.
  - 2 = MAX: lane0 = unsigned max; lanes 1..N-1 = 0.
  - Any other opcode behaves as PASS.
- Opcode lookup: the opcode is looked up from firmware_op[chainId_in] in the input-register cycle. It travels with the data, so a per-beat chain change takes effect on that beat.
- Reduction tree: log2(N) registered levels. Each level halves the lane count with a pairwise add (SUM) or unsigned compare-select (MAX). For PASS, the full vector, opcode and sideband are carried alongside in matching delay registers.
- Arithmetic: unsigned; sums truncate to DATA_WIDTH with no saturation. MAX ties select the lower-index lane. The result is value-identical either way.
- Config mode (tracing = 0):
  - When configId == PERSONAL_CONFIG_ID, byte k (k < MAX_CHAINS) is written to firmware_op[k] and an 8-bit byte counter increments.
  - Bytes with k ≥ MAX_CHAINS are ignored.
  - When configId differs, the counter clears to 0.
- Stream mode (tracing = 1): config bus ignored; the counter holds.
- The pipeline advances every cycle regardless of tracing. valid_out = pipelined valid AND tracing (sampled at the output register). In-flight beats that emerge while tracing = 0 are dropped.
- No backpressure; the block accepts one vector per cycle.

## Timing
- Latency: 1 + log2(N) cycles from valid_in to valid_out (4 for N = 8). The input register is 1 cycle; each tree level is 1 cycle.
- eof/bof/chainId are delayed by exactly the same latency as the data.
- Throughput: 1 vector/cycle; back-to-back beats with mixed opcodes/chains are legal.
- Reset (asynchronous assert, synchronous to clk on release):
  - Cleared to 0: all valid pipeline bits, valid_out, vector_out, eof_out, bof_out, chainId_out, byte counter.
  - firmware_op reloads INITIAL_FIRMWARE_OP.
- Reset mid-stream: all in-flight beats are discarded; the first post-reset beat appears at the full latency.
- Config write on the same cycle tracing rises: the write does not happen (tracing = 1 wins).
- A firmware update does not affect beats already past the input register.

## Structure
- Package vector_reduce_pkg:
  - Opcode constants OP_PASS = 0, OP_SUM = 1, OP_MAX = 2.
  - A typedef for the sideband bundle (valid, eof, bof, chainId, op).
- Sub-module reduce_tree_level, parameterised on input lane count, DATA_WIDTH and sideband width. It holds one registered pairwise level and is instantiated log2(N) times in a generate loop.
- The top holds the firmware table, config counter, input register, PASS delay line and output register.

## Test plan
- Reset defaults, N = 8, firmware all 0: vector_in = {1..8}, valid_in = 1, tracing = 1 → 4 cycles later vector_out = {1..8}, valid_out = 1, same eof/bof/chainId.
- Config load: tracing = 0, configId = 0, bytes 1,2,0,1 → firmware_op = {1,2,0,1}. Then stream chain 0 with {1..8} → lane0 = 36, other lanes 0. Stream chain 1 with {5,9,3,…,0} → lane0 = 9.
- Overflow: SUM on all lanes 0xFFFF_FFFF → lane0 = 0xFFFF_FFF8.
- Back-to-back beats on chains 0,1,2,3 with distinct data → four consecutive valid outputs in order with the correct opcodes applied. Each output has chainId_out/eof_out/bof_out aligned to its own beat.
- tracing drops 2 cycles after a beat enters → valid_out stays 0 for that beat. Meanwhile configId ≠ 0 clears the byte counter.
- reset asserted while 3 beats are in flight → outputs are 0 immediately (asynchronous). No stale valid_out appears after release.
